// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: TX scheduler state/source encodings and the
// round-robin source pick used when both senders are pending.
package eth_pkg;

  localparam int unsigned ETH_IFG_BYTES = 12;
  localparam int unsigned ETH_BYTE_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_SOF,
    SEND,
    IFG
  } tx_sched_state_t;

  typedef enum logic {
    SRC_ARP,
    SRC_UDP
  } tx_src_t;

  // Single pending source wins outright; a tie goes to the source not granted last.
  function automatic tx_src_t tx_sched_pick(input logic    arp_pend,
                                            input logic    udp_pend,
                                            input tx_src_t last_src);
    tx_src_t pick;
    if (arp_pend && !udp_pend) begin
      pick = SRC_ARP;
    end else if (udp_pend && !arp_pend) begin
      pick = SRC_UDP;
    end else begin
      pick = (last_src == SRC_UDP) ? SRC_ARP : SRC_UDP;
    end
    return pick;
  endfunction

endpackage

// File: rtl/eth_tx_sched.sv
// TX scheduler for the shared GMII/MII port: grants ARP/UDP senders one at a
// time, forwards the granted byte stream and enforces the inter-frame gap.
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int unsigned IFG_CYCLES    = ETH_IFG_BYTES,
  parameter int unsigned START_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_arp_req,
  input  logic                  i_udp_req,
  output logic                  o_arp_enable,
  output logic                  o_udp_enable,
  input  logic [ETH_BYTE_W-1:0] i_arp_tx_data,
  input  logic                  i_arp_tx_en,
  input  logic [ETH_BYTE_W-1:0] i_udp_tx_data,
  input  logic                  i_udp_tx_en,
  output logic [ETH_BYTE_W-1:0] o_tx_data,
  output logic                  o_tx_en,
  output logic                  o_busy,
  output logic                  o_arp_done,
  output logic                  o_udp_done,
  output logic                  o_timeout
);

  localparam int unsigned CNT_MAX = (IFG_CYCLES > START_TIMEOUT) ? IFG_CYCLES : START_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(START_TIMEOUT - 1);

  tx_sched_state_t       state_q, state_d;
  tx_src_t               sel_q, sel_d;
  tx_src_t               last_q, last_d;
  tx_src_t               pick;
  logic                  grant;
  logic                  arp_pend_q, arp_pend_d;
  logic                  udp_pend_q, udp_pend_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  arp_en_q, arp_en_d;
  logic                  udp_en_q, udp_en_d;
  logic                  arp_done_q, arp_done_d;
  logic                  udp_done_q, udp_done_d;
  logic                  timeout_q, timeout_d;
  logic                  busy_q, busy_d;
  logic                  tx_en_q, tx_en_d;
  logic [ETH_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                  fwd;
  logic                  sel_tx_en;
  logic [ETH_BYTE_W-1:0] sel_tx_data;

  // Source select is frozen from START until IFG exits, so the mux never swaps mid-frame.
  assign sel_tx_en   = (sel_q == SRC_ARP) ? i_arp_tx_en   : i_udp_tx_en;
  assign sel_tx_data = (sel_q == SRC_ARP) ? i_arp_tx_data : i_udp_tx_data;

  // Next-state, pending flags, counter and registered-output next values.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    grant      = 1'b0;
    arp_done_d = 1'b0;
    udp_done_d = 1'b0;
    timeout_d  = 1'b0;
    pick       = tx_sched_pick(arp_pend_q, udp_pend_q, last_q);

    case (state_q)
      IDLE: begin
        if (arp_pend_q || udp_pend_q) begin
          state_d = START;
          sel_d   = pick;
          last_d  = pick;
          grant   = 1'b1;
        end
      end
      START: state_d = WAIT_SOF;
      WAIT_SOF: begin
        if (sel_tx_en) begin
          state_d = SEND;
        end else if (cnt_q >= TMO_LAST) begin
          state_d   = IFG;
          timeout_d = 1'b1;
        end
      end
      SEND: begin
        if (!sel_tx_en) begin
          state_d    = IFG;
          arp_done_d = (sel_q == SRC_ARP);
          udp_done_d = (sel_q == SRC_UDP);
        end
      end
      IFG: begin
        if (cnt_q >= IFG_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A request arriving in the grant cycle keeps its flag set.
    arp_pend_d = i_arp_req | (arp_pend_q & ~(grant & (pick == SRC_ARP)));
    udp_pend_d = i_udp_req | (udp_pend_q & ~(grant & (pick == SRC_UDP)));

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    arp_en_d  = grant & (pick == SRC_ARP);
    udp_en_d  = grant & (pick == SRC_UDP);
    busy_d    = (state_d != IDLE);
    fwd       = (state_q == WAIT_SOF) || (state_q == SEND);
    tx_en_d   = fwd & sel_tx_en;
    tx_data_d = fwd ? sel_tx_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= SRC_ARP;
      last_q     <= SRC_UDP;
      arp_pend_q <= 1'b0;
      udp_pend_q <= 1'b0;
      cnt_q      <= '0;
      arp_en_q   <= 1'b0;
      udp_en_q   <= 1'b0;
      arp_done_q <= 1'b0;
      udp_done_q <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      arp_pend_q <= arp_pend_d;
      udp_pend_q <= udp_pend_d;
      cnt_q      <= cnt_d;
      arp_en_q   <= arp_en_d;
      udp_en_q   <= udp_en_d;
      arp_done_q <= arp_done_d;
      udp_done_q <= udp_done_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign o_arp_enable = arp_en_q;
  assign o_udp_enable = udp_en_q;
  assign o_arp_done   = arp_done_q;
  assign o_udp_done   = udp_done_q;
  assign o_timeout    = timeout_q;
  assign o_busy       = busy_q;
  assign o_tx_en      = tx_en_q;
  assign o_tx_data    = tx_data_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Scoreboard bench for eth_tx_sched: stimulus queues expected events/bytes,
// a negedge monitor pops and compares whenever the scheduler presents output.
module tb_eth_tx_sched;

  localparam int EV_ARP_EN   = 0;
  localparam int EV_UDP_EN   = 1;
  localparam int EV_ARP_DONE = 2;
  localparam int EV_UDP_DONE = 3;
  localparam int EV_TMO      = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arp_req = 1'b0;
  logic       udp_req = 1'b0;
  logic       arp_eng_en = 1'b0;
  logic [7:0] arp_eng_data = 8'h00;
  logic       udp_eng_en = 1'b0;
  logic [7:0] udp_eng_data = 8'h00;
  logic       stray_en = 1'b0;
  logic       udp_tx_en_w;
  logic [7:0] udp_tx_data_w;

  logic       o_arp_enable, o_udp_enable, o_tx_en, o_busy;
  logic       o_arp_done, o_udp_done, o_timeout;
  logic [7:0] o_tx_data;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   arp_len = 0;
  int   udp_len = 0;
  ev_t  exp_ev[$];
  logic [7:0] exp_bytes[$];

  assign udp_tx_en_w   = udp_eng_en | stray_en;
  assign udp_tx_data_w = stray_en ? 8'hAA : udp_eng_data;

  eth_tx_sched #(.IFG_CYCLES(12), .START_TIMEOUT(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_arp_req    (arp_req),
    .i_udp_req    (udp_req),
    .o_arp_enable (o_arp_enable),
    .o_udp_enable (o_udp_enable),
    .i_arp_tx_data(arp_eng_data),
    .i_arp_tx_en  (arp_eng_en),
    .i_udp_tx_data(udp_tx_data_w),
    .i_udp_tx_en  (udp_tx_en_w),
    .o_tx_data    (o_tx_data),
    .o_tx_en      (o_tx_en),
    .o_busy       (o_busy),
    .o_arp_done   (o_arp_done),
    .o_udp_done   (o_udp_done),
    .o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_ev.push_back(e);
  endtask

  task automatic chk_evt(input int kind);
    ev_t e;
    total++;
    if (exp_ev.size() == 0) begin
      bad++;
      $display("FAIL evt_unexpected kind=%0d cyc=%0d want=none", kind, cyc);
    end else begin
      e = exp_ev.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        bad++;
        $display("FAIL evt got kind=%0d cyc=%0d want kind=%0d cyc=%0d", kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  // Monitor: every presented event or byte is matched against the scoreboard.
  always @(negedge clk) begin
    if (o_arp_enable) chk_evt(EV_ARP_EN);
    if (o_udp_enable) chk_evt(EV_UDP_EN);
    if (o_arp_done)   chk_evt(EV_ARP_DONE);
    if (o_udp_done)   chk_evt(EV_UDP_DONE);
    if (o_timeout)    chk_evt(EV_TMO);
    if (o_tx_en) begin
      if (exp_bytes.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected cyc=%0d got=%0h want=none", cyc, o_tx_data);
      end else begin
        check("tx_data", 32'(o_tx_data), 32'(exp_bytes.pop_front()));
      end
    end else if (o_tx_data != 8'h00) begin
      check("idle_data", 32'(o_tx_data), 32'h0);
    end
  end

  // Engine models: start driving 3 cycles after their enable pulse.
  initial begin : arp_engine
    forever begin
      @(negedge clk);
      if (o_arp_enable && arp_len > 0) begin
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < arp_len; i++) begin
          arp_eng_en   = 1'b1;
          arp_eng_data = 8'(8'h10 + i);
          exp_bytes.push_back(arp_eng_data);
          @(posedge clk);
          #1;
        end
        arp_eng_en   = 1'b0;
        arp_eng_data = 8'h00;
      end
    end
  end

  initial begin : udp_engine
    forever begin
      @(negedge clk);
      if (o_udp_enable && udp_len > 0) begin
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < udp_len; i++) begin
          udp_eng_en   = 1'b1;
          udp_eng_data = 8'(8'h60 + i);
          exp_bytes.push_back(udp_eng_data);
          @(posedge clk);
          #1;
        end
        udp_eng_en   = 1'b0;
        udp_eng_data = 8'h00;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse(input logic a, input logic u);
    arp_req = a;
    udp_req = u;
    next_cycle();
    arp_req = 1'b0;
    udp_req = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    #3;
    check("rst_tx_en", 32'(o_tx_en), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_arp_en", 32'(o_arp_enable), 0);
    check("rst_udp_en", 32'(o_udp_enable), 0);
    check("rst_done_tmo", 32'({o_arp_done, o_udp_done, o_timeout}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Tie after reset: ARP first, UDP after a full gap.
    arp_len = 20;
    udp_len = 20;
    next_cycle();
    n = cyc;
    push_ev(EV_ARP_EN, n + 2);
    push_ev(EV_ARP_DONE, n + 26);
    push_ev(EV_UDP_EN, n + 39);
    push_ev(EV_UDP_DONE, n + 63);
    pulse(1'b1, 1'b1);
    repeat (90) next_cycle();
    check("tie1_idle", 32'(o_busy), 0);

    // Second tie: last grant was UDP, so ARP again.
    n = cyc;
    push_ev(EV_ARP_EN, n + 2);
    push_ev(EV_ARP_DONE, n + 26);
    push_ev(EV_UDP_EN, n + 39);
    push_ev(EV_UDP_DONE, n + 63);
    pulse(1'b1, 1'b1);
    repeat (90) next_cycle();
    check("tie2_idle", 32'(o_busy), 0);

    // ARP only, 42-byte frame.
    arp_len = 42;
    n = cyc;
    push_ev(EV_ARP_EN, n + 2);
    push_ev(EV_ARP_DONE, n + 48);
    pulse(1'b1, 1'b0);
    wait_cyc(n + 30);
    check("arp_busy_mid", 32'(o_busy), 1);
    repeat (70) next_cycle();
    check("arp_idle", 32'(o_busy), 0);

    // Three UDP requests during SEND merge into one further frame.
    udp_len = 30;
    next_cycle();
    n = cyc;
    push_ev(EV_UDP_EN, n + 2);
    push_ev(EV_UDP_DONE, n + 36);
    push_ev(EV_UDP_EN, n + 49);
    push_ev(EV_UDP_DONE, n + 83);
    pulse(1'b0, 1'b1);
    wait_cyc(n + 10);
    pulse(1'b0, 1'b1);
    wait_cyc(n + 15);
    pulse(1'b0, 1'b1);
    wait_cyc(n + 20);
    pulse(1'b0, 1'b1);
    repeat (110) next_cycle();
    check("b2b_idle", 32'(o_busy), 0);

    // Engine never answers: timeout, then the gap is still served.
    udp_len = 0;
    n = cyc;
    push_ev(EV_UDP_EN, n + 2);
    push_ev(EV_TMO, n + 67);
    pulse(1'b0, 1'b1);
    wait_cyc(n + 78);
    check("tmo_busy_ifg", 32'(o_busy), 1);
    wait_cyc(n + 79);
    check("tmo_busy_idle", 32'(o_busy), 0);
    repeat (10) next_cycle();

    // Stray UDP tx_en with 0xAA across an ARP frame must not leak.
    arp_len = 20;
    n = cyc;
    push_ev(EV_ARP_EN, n + 2);
    push_ev(EV_ARP_DONE, n + 26);
    pulse(1'b1, 1'b0);
    wait_cyc(n + 3);
    stray_en = 1'b1;
    wait_cyc(n + 30);
    stray_en = 1'b0;
    repeat (30) next_cycle();
    check("stray_idle", 32'(o_busy), 0);

    // Async reset mid-SEND with a UDP request pending.
    n = cyc;
    push_ev(EV_ARP_EN, n + 2);
    pulse(1'b1, 1'b0);
    wait_cyc(n + 8);
    pulse(1'b0, 1'b1);
    wait_cyc(n + 10);
    check("pre_rst_tx_en", 32'(o_tx_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx_en", 32'(o_tx_en), 0);
    check("async_rst_busy", 32'(o_busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) next_cycle();
    check("post_rst_busy", 32'(o_busy), 0);
    check("post_rst_tx_en", 32'(o_tx_en), 0);
    exp_bytes.delete();

    check("ev_queue_empty", 32'(exp_ev.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
